fog_lin_interp: RTL and testbench

- Linear interpolating upsampler for the FOG/PIG data path; the inverse-rate counterpart of the power-of-two moving-average decimator.
- Accepts coarse signed 32-bit samples on a slow input strobe and emits L = 2^sel linearly interpolated samples per input interval on a fast output strobe.
- Used to feed averaged rate data into fast-tick consumers (DAC/feedback/output framing) without step discontinuities.

---
 rtl/fog_lin_interp.sv | 172 +++++++++++++++++
 tb/tb_fog_lin_interp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fog_lin_interp.sv
// rtl/fog_lin_interp.sv - linear interpolating power-of-two upsampler
//
// Purpose: accepts coarse signed samples on a slow input strobe and emits
// L = 2^sel linearly interpolated samples per input interval on a fast
// output strobe, so fast-tick consumers see no step discontinuities.
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_in_strobe       one-cycle pulse, i_data valid
//   i_data            signed coarse sample
//   i_out_strobe      one-cycle output tick request
//   i_ratio_sel       log2 of upsampling ratio (clamped to MAX_SEL)
//   i_clr_flags       clears sticky flags
//   o_data            signed interpolated sample
//   o_valid           one-cycle pulse, o_data updated
//   o_underrun        sticky, segment ended with no new sample
//   o_overrun         sticky, pending sample overwritten
//   o_active          high once first sample is accepted
module fog_lin_interp #(
    parameter int MAX_SEL = 15,
    parameter int ACC_W   = 48
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_strobe,
    input  logic [31:0] i_data,
    input  logic        i_out_strobe,
    input  logic [3:0]  i_ratio_sel,
    input  logic        i_clr_flags,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_underrun,
    output logic        o_overrun,
    output logic        o_active
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                   state_q, state_d;
    logic signed [31:0]       p1_q, p1_d;
    logic signed [31:0]       pend_q, pend_d;
    logic signed [31:0]       data_q, data_d;
    logic signed [32:0]       delta_q, delta_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [14:0]              phase_q, phase_d;
    logic [3:0]               sel_q, sel_d;
    logic                     pend_v_q, pend_v_d;
    logic                     valid_q, valid_d;
    logic                     underrun_q, underrun_d;
    logic                     overrun_q, overrun_d;
    logic                     active_q, active_d;

    logic [3:0]               sel_req;
    logic [15:0]              last_phase;
    logic                     seg_end;
    logic                     set_under;
    logic                     set_over;
    logic signed [31:0]       next_smp;

    assign sel_req    = ({1'b0, i_ratio_sel} > 5'(MAX_SEL)) ? 4'(MAX_SEL) : i_ratio_sel;
    assign last_phase = (16'd1 << sel_q) - 16'd1;
    assign seg_end    = ({1'b0, phase_q} == last_phase);

    always_comb begin
        state_d    = state_q;
        p1_d       = p1_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        data_d     = data_q;
        delta_d    = delta_q;
        acc_d      = acc_q;
        phase_d    = phase_q;
        sel_d      = sel_q;
        active_d   = active_q;
        valid_d    = 1'b0;
        set_under  = 1'b0;
        set_over   = 1'b0;
        next_smp   = p1_q;

        case (state_q)
            ST_IDLE: begin
                // First segment is flat at the first sample (delta = 0).
                if (i_in_strobe) begin
                    p1_d     = $signed(i_data);
                    acc_d    = ACC_W'($signed(i_data)) <<< sel_req;
                    delta_d  = '0;
                    phase_d  = '0;
                    sel_d    = sel_req;
                    active_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_out_strobe) begin
                    valid_d = 1'b1;
                    // acc holds value scaled by L; arithmetic shift floors.
                    data_d  = 32'(acc_q >>> sel_q);
                    if (!seg_end) begin
                        acc_d   = acc_q + ACC_W'(delta_q);
                        phase_d = phase_q + 15'd1;
                    end else begin
                        sel_d   = sel_req;
                        phase_d = '0;
                        if (pend_v_q) begin
                            next_smp = pend_q;
                            // Coincident input refills the slot in FIFO order.
                            if (i_in_strobe) pend_d = $signed(i_data);
                            else             pend_v_d = 1'b0;
                        end else if (i_in_strobe) begin
                            next_smp = $signed(i_data);
                        end else begin
                            next_smp  = p1_q;
                            set_under = 1'b1;
                        end
                        // Restart from exact segment end to avoid drift.
                        delta_d = 33'(next_smp) - 33'(p1_q);
                        acc_d   = ACC_W'(p1_q) <<< sel_req;
                        p1_d    = next_smp;
                    end
                end
                if (i_in_strobe && !(i_out_strobe && seg_end)) begin
                    pend_d   = $signed(i_data);
                    pend_v_d = 1'b1;
                    set_over = pend_v_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        underrun_d = (underrun_q & ~i_clr_flags) | set_under;
        overrun_d  = (overrun_q  & ~i_clr_flags) | set_over;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            p1_q       <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            data_q     <= '0;
            delta_q    <= '0;
            acc_q      <= '0;
            phase_q    <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            p1_q       <= p1_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            data_q     <= data_d;
            delta_q    <= delta_d;
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            active_q   <= active_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_underrun = underrun_q;
    assign o_overrun  = overrun_q;
    assign o_active   = active_q;

endmodule

// File: tb/tb_fog_lin_interp.sv
// tb/tb_fog_lin_interp.sv - directed self-checking bench for fog_lin_interp
module tb_fog_lin_interp;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_in_strobe;
    logic [31:0] i_data;
    logic        i_out_strobe;
    logic [3:0]  i_ratio_sel;
    logic        i_clr_flags;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_underrun;
    logic        o_overrun;
    logic        o_active;

    int n_chk  = 0;
    int n_fail = 0;

    fog_lin_interp dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_in_strobe  (i_in_strobe),
        .i_data       (i_data),
        .i_out_strobe (i_out_strobe),
        .i_ratio_sel  (i_ratio_sel),
        .i_clr_flags  (i_clr_flags),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_underrun   (o_underrun),
        .o_overrun    (o_overrun),
        .o_active     (o_active)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs applied just after a rising edge, sampled 1 time unit after the next.
    task automatic step(input logic in_stb, input logic signed [31:0] din,
                        input logic out_stb, input logic clr);
        i_in_strobe  = in_stb;
        i_data       = din;
        i_out_strobe = out_stb;
        i_clr_flags  = clr;
        @(posedge i_clk);
        #1;
        i_in_strobe  = 1'b0;
        i_out_strobe = 1'b0;
        i_clr_flags  = 1'b0;
    endtask

    task automatic tick(input string tag, input logic signed [31:0] exp,
                        input logic in_stb = 1'b0, input logic signed [31:0] din = 0,
                        input logic clr = 1'b0);
        step(in_stb, din, 1'b1, clr);
        chk({tag, "_valid"}, {31'd0, o_valid}, 1);
        chk(tag, $signed(o_data), exp);
    endtask

    task automatic push(input logic signed [31:0] din);
        step(1'b1, din, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_in_strobe  = 1'b0;
        i_data       = '0;
        i_out_strobe = 1'b0;
        i_ratio_sel  = 4'd2;
        i_clr_flags  = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_data",     $signed(o_data), 0);
        chk("rst_valid",    {31'd0, o_valid}, 0);
        chk("rst_underrun", {31'd0, o_underrun}, 0);
        chk("rst_overrun",  {31'd0, o_overrun}, 0);
        chk("rst_active",   {31'd0, o_active}, 0);
        i_rst_n = 1'b1;

        // A: sel=2, 0 -> 100 -> 200
        push(0);
        chk("a_active", {31'd0, o_active}, 1);
        chk("a_novalid", {31'd0, o_valid}, 0);
        tick("a1", 0); tick("a2", 0); tick("a3", 0);
        push(100);
        tick("a4", 0);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("a_valid_pulse", {31'd0, o_valid}, 0);
        tick("a5", 0); tick("a6", 25); tick("a7", 50);
        push(200);
        tick("a8", 75);
        tick("a9", 100); tick("a10", 125); tick("a11", 150); tick("a12", 175);
        chk("a_overrun", {31'd0, o_overrun}, 0);

        // B: sel=1, negative values floor toward -inf
        reset_dut();
        i_ratio_sel = 4'd1;
        push(-7);
        tick("b1", -7);
        push(0);
        tick("b2", -7);
        push(0);
        tick("b3", -7); tick("b4", -4);
        tick("b5", 0);
        tick("b6", 0, 1'b1, 0);
        chk("b_underrun", {31'd0, o_underrun}, 0);
        chk("b_overrun",  {31'd0, o_overrun}, 0);

        // C: sel=2, underrun at second boundary, clear, and set-beats-clear
        reset_dut();
        i_ratio_sel = 4'd2;
        push(10);
        tick("c1", 10); tick("c2", 10); tick("c3", 10);
        push(50);
        tick("c4", 10);
        chk("c_no_underrun", {31'd0, o_underrun}, 0);
        tick("c5", 10); tick("c6", 20); tick("c7", 30); tick("c8", 40);
        chk("c_underrun", {31'd0, o_underrun}, 1);
        tick("c9", 50); tick("c10", 50); tick("c11", 50); tick("c12", 50);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("c_clr", {31'd0, o_underrun}, 0);
        tick("c13", 50); tick("c14", 50); tick("c15", 50);
        tick("c16", 50, 1'b0, 0, 1'b1);
        chk("c_set_wins", {31'd0, o_underrun}, 1);

        // D: overrun, then coincident input at segment end keeps FIFO order
        reset_dut();
        push(0);
        tick("d1", 0);
        push(5);
        push(9);
        chk("d_overrun", {31'd0, o_overrun}, 1);
        tick("d2", 0); tick("d3", 0); tick("d4", 0);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("d_clr", {31'd0, o_overrun}, 0);
        tick("d5", 0); tick("d6", 2); tick("d7", 4);
        push(20);
        tick("d8", 6, 1'b1, 30);
        chk("d_no_overrun", {31'd0, o_overrun}, 0);
        tick("d9", 9); tick("d10", 11); tick("d11", 14); tick("d12", 17);
        tick("d13", 20); tick("d14", 22);
        chk("d_no_overrun2", {31'd0, o_overrun}, 0);

        // E: ratio change waits for boundary; then sel=0 passthrough
        reset_dut();
        i_ratio_sel = 4'd2;
        push(0);
        push(80);
        tick("e1", 0); tick("e2", 0);
        i_ratio_sel = 4'd3;
        tick("e3", 0); tick("e4", 0);
        tick("e5", 0);  tick("e6", 10); tick("e7", 20); tick("e8", 30);
        tick("e9", 40); tick("e10", 50); tick("e11", 60);
        push(100);
        i_ratio_sel = 4'd0;
        tick("e12", 70);
        tick("e13", 80, 1'b1, 110);
        tick("e14", 100, 1'b1, 120);
        tick("e15", 110, 1'b1, 130);

        // F: asynchronous reset mid-segment, IDLE ignores ticks, pend discarded
        i_ratio_sel = 4'd2;
        push(7);
        i_rst_n = 1'b0;
        #1;
        chk("f_data",     $signed(o_data), 0);
        chk("f_valid",    {31'd0, o_valid}, 0);
        chk("f_underrun", {31'd0, o_underrun}, 0);
        chk("f_overrun",  {31'd0, o_overrun}, 0);
        chk("f_active",   {31'd0, o_active}, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 1'b1, 1'b0);
            chk("f_idle_valid", {31'd0, o_valid}, 0);
            chk("f_idle_data", $signed(o_data), 0);
        end
        push(40);
        tick("f1", 40); tick("f2", 40); tick("f3", 40); tick("f4", 40);
        chk("f_pend_gone", {31'd0, o_underrun}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
